// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU: opcodes, sequencer
// phase encodings and the ALU-operation membership test.
package cpu_pkg;

  localparam int OPW = 3;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // HALTED keeps the low bits at 4 so the debug phase shows where it stopped.
  localparam logic [3:0] S_P0   = 4'd0;
  localparam logic [3:0] S_P1   = 4'd1;
  localparam logic [3:0] S_P2   = 4'd2;
  localparam logic [3:0] S_P3   = 4'd3;
  localparam logic [3:0] S_P4   = 4'd4;
  localparam logic [3:0] S_P5   = 4'd5;
  localparam logic [3:0] S_P6   = 4'd6;
  localparam logic [3:0] S_P7   = 4'd7;
  localparam logic [3:0] S_HALT = 4'b1100;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) ||
           (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_ctl_seq.sv
// Eight-phase fetch/execute control sequencer with memory wait states
// and a sticky HLT state.
// Ports: clk, rst (sync, active-high), ena, opcode, zero, mem_rdy in;
//        sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt,
//        phase[2:0] out.
module cpu_ctl_seq
  import cpu_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_rdy,
  output logic           sel,
  output logic           rd,
  output logic           wr,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           ld_ac,
  output logic           data_e,
  output logic           halt,
  output logic [2:0]     phase
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_alu;
  logic       w_sto;
  logic       w_jmp;
  logic       w_skz;
  logic       w_hlt;
  logic       w_done7;

  assign w_alu = is_aluop(opcode);
  assign w_sto = (opcode == OP_STO);
  assign w_jmp = (opcode == OP_JMP);
  assign w_skz = (opcode == OP_SKZ);
  assign w_hlt = (opcode == OP_HLT);

  // P7 only waits on memory for ops that touch it; others finish at once.
  assign w_done7 = !(w_alu || w_sto) || mem_rdy;

  assign phase = r_state[2:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_P0;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    unique case (r_state)
      S_P0: begin
        sel = 1'b1;
        if (ena) w_next = S_P1;
      end
      S_P1: begin
        sel    = 1'b1;
        rd     = 1'b1;
        w_next = S_P2;
      end
      S_P2: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = mem_rdy;
        if (mem_rdy) w_next = S_P3;
      end
      S_P3: begin
        sel    = 1'b1;
        rd     = 1'b1;
        w_next = S_P4;
      end
      S_P4: begin
        inc_pc = 1'b1;
        halt   = w_hlt;
        w_next = w_hlt ? S_HALT : S_P5;
      end
      S_P5: begin
        rd     = w_alu;
        w_next = S_P6;
      end
      S_P6: begin
        rd     = w_alu;
        inc_pc = w_skz && zero;
        ld_pc  = w_jmp;
        data_e = w_sto;
        w_next = S_P7;
      end
      S_P7: begin
        rd     = w_alu;
        data_e = w_sto;
        ld_ac  = w_alu && w_done7;
        wr     = w_sto && w_done7;
        ld_pc  = w_jmp && w_done7;
        inc_pc = w_jmp && w_done7;
        if (w_done7) w_next = S_P0;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        w_next = S_P0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctl_seq.sv
// Scoreboard bench for cpu_ctl_seq: instruction-level expected traces
// are queued by the driver and compared per cycle by a monitor.
module tb_cpu_ctl_seq;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
  logic [2:0] phase;

  cpu_ctl_seq #(.OPW(3)) dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode),
    .zero(zero), .mem_rdy(mem_rdy),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac),
    .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] v;
    logic [11:0] m;
    string       tag;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [11:0] ALL  = 12'hFFF;
  localparam logic [11:0] NOPH = 12'h1FF;

  // Bit order: phase[11:9] sel rd wr ld_ir inc_pc ld_pc ld_ac data_e halt
  function automatic logic [11:0] ev(
    input int ph, input bit s, input bit r, input bit w,
    input bit li, input bit ip, input bit lp, input bit la,
    input bit de, input bit h);
    logic [2:0] p;
    p = ph[2:0];
    return {p, s, r, w, li, ip, lp, la, de, h};
  endfunction

  function automatic bit mem_op(input logic [2:0] op);
    case (op)
      OP_ADD, OP_AND, OP_XOR, OP_LDA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e = q.pop_front();
      act = {phase, sel, rd, wr, ld_ir, inc_pc, ld_pc,
             ld_ac, data_e, halt};
      n_cmp++;
      if ((act & e.m) !== (e.v & e.m)) begin
        n_bad++;
        $display("FAIL %s t=%0t got=%h want=%h mask=%h",
                 e.tag, $time, act, e.v, e.m);
      end
    end
  end

  task automatic cyc(input bit r, input bit e, input logic [2:0] op,
                     input bit z, input bit rdy, input logic [11:0] v,
                     input logic [11:0] m, input string tag);
    exp_t x;
    rst = r; ena = e; opcode = op; zero = z; mem_rdy = rdy;
    x.v = v; x.m = m; x.tag = tag;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  // One full instruction: idle P0 cycles, fetch with w2 waits,
  // execute with w7 waits (only for memory ops). HLT ends in a reset.
  task automatic run_instr(input logic [2:0] op, input bit z,
                           input int idle, input int w2, input int w7);
    bit al, st, jm, sk;
    al = mem_op(op);
    st = (op == OP_STO);
    jm = (op == OP_JMP);
    sk = (op == OP_SKZ);
    for (int i = 0; i < idle; i++)
      cyc(0, 0, rop(), rb(), rb(), ev(0,1,0,0,0,0,0,0,0,0), ALL, "p0_idle");
    cyc(0, 1, rop(), rb(), rb(), ev(0,1,0,0,0,0,0,0,0,0), ALL, "p0");
    cyc(0, rb(), rop(), rb(), rb(), ev(1,1,1,0,0,0,0,0,0,0), ALL, "p1");
    for (int i = 0; i < w2; i++)
      cyc(0, rb(), rop(), rb(), 0, ev(2,1,1,0,0,0,0,0,0,0), ALL, "p2_wait");
    cyc(0, rb(), rop(), rb(), 1, ev(2,1,1,0,1,0,0,0,0,0), ALL, "p2");
    cyc(0, rb(), op, rb(), rb(), ev(3,1,1,0,0,0,0,0,0,0), ALL, "p3");
    if (op == OP_HLT) begin
      cyc(0, rb(), op, rb(), rb(), ev(4,0,0,0,0,1,0,0,0,1), ALL, "p4_hlt");
      for (int i = 0; i < 3; i++)
        cyc(0, rb(), rop(), rb(), rb(), ev(0,0,0,0,0,0,0,0,0,1), NOPH,
            "halted");
      cyc(1, rb(), rop(), rb(), rb(), ev(0,0,0,0,0,0,0,0,0,1), NOPH,
          "halt_rst");
      cyc(0, 0, rop(), rb(), rb(), ev(0,1,0,0,0,0,0,0,0,0), ALL,
          "after_rst");
      return;
    end
    cyc(0, rb(), op, rb(), rb(), ev(4,0,0,0,0,1,0,0,0,0), ALL, "p4");
    cyc(0, rb(), op, rb(), rb(), ev(5,0,al,0,0,0,0,0,0,0), ALL, "p5");
    cyc(0, rb(), op, z, rb(), ev(6,0,al,0,0,sk&z,jm,0,st,0), ALL, "p6");
    if (al || st) begin
      for (int i = 0; i < w7; i++)
        cyc(0, rb(), op, rb(), 0, ev(7,0,al,0,0,0,0,0,st,0), ALL,
            "p7_wait");
      cyc(0, rb(), op, rb(), 1, ev(7,0,al,st,0,0,0,al,st,0), ALL, "p7");
    end else begin
      cyc(0, rb(), op, rb(), rb(), ev(7,0,0,0,0,jm,jm,0,0,0), ALL, "p7");
    end
  endtask

  initial begin
    logic [2:0] op;
    @(posedge clk);
    #1;
    cyc(1, 1, rop(), rb(), rb(), ev(0,1,0,0,0,0,0,0,0,0), ALL, "reset");
    run_instr(OP_ADD, 0, 0, 0, 0);
    run_instr(OP_ADD, 1, 0, 0, 0);
    run_instr(OP_STO, 0, 0, 0, 0);
    run_instr(OP_SKZ, 1, 0, 0, 0);
    run_instr(OP_SKZ, 0, 0, 0, 0);
    run_instr(OP_JMP, 0, 0, 0, 0);
    run_instr(OP_ADD, 0, 0, 3, 0);
    run_instr(OP_STO, 0, 2, 1, 2);
    run_instr(OP_LDA, 0, 1, 0, 3);
    run_instr(OP_HLT, 0, 0, 0, 0);
    // Reset mid-fetch while waiting on memory.
    cyc(0, 1, rop(), rb(), rb(), ev(0,1,0,0,0,0,0,0,0,0), ALL, "m_p0");
    cyc(0, 1, rop(), rb(), rb(), ev(1,1,1,0,0,0,0,0,0,0), ALL, "m_p1");
    cyc(1, 1, rop(), rb(), 0, ev(2,1,1,0,0,0,0,0,0,0), ALL, "m_rst");
    cyc(0, 0, rop(), rb(), rb(), ev(0,1,0,0,0,0,0,0,0,0), ALL, "m_p0b");
    for (int n = 0; n < 150; n++) begin
      op = rop();
      if (op == OP_HLT && $urandom_range(0, 3) != 0) op = OP_XOR;
      run_instr(op, rb(), $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain left=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
